// File: rtl/axilite_apb_pkg.sv
// Shared types and constants for the AXI-Lite <-> APB bridge family.
// Holds the bridge FSM state encoding and the AXI response codes.
package axilite_apb_pkg;

   localparam int DEFAULT_AW = 32;
   localparam int DEFAULT_DW = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RSP,
      RD_REQ,
      RD_RSP,
      DONE
   } state_t;

   // SLVERR and DECERR are both reported to APB as a slave error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/apb_to_axilite.sv
// APB slave to AXI4-Lite master bridge: each APB transfer is replayed as one
// AXI-Lite transaction, holding PREADY low until the AXI response returns.
module apb_to_axilite
   import axilite_apb_pkg::*;
#(
   parameter int AW = DEFAULT_AW,
   parameter int DW = DEFAULT_DW
) (
   input  logic            axi_clk,
   input  logic            sys_areset,

   input  logic [AW-1:0]   s_apb_paddr,
   input  logic            s_apb_psel,
   input  logic            s_apb_penable,
   input  logic            s_apb_pwrite,
   input  logic [DW-1:0]   s_apb_pwdata,
   input  logic [DW/8-1:0] s_apb_pstrb,
   input  logic [2:0]      s_apb_pprot,
   output logic            s_apb_pready,
   output logic [DW-1:0]   s_apb_prdata,
   output logic            s_apb_pslverr,

   output logic [AW-1:0]   m_axi_awaddr,
   output logic [2:0]      m_axi_awprot,
   output logic            m_axi_awvalid,
   input  logic            m_axi_awready,

   output logic [DW-1:0]   m_axi_wdata,
   output logic [DW/8-1:0] m_axi_wstrb,
   output logic            m_axi_wvalid,
   input  logic            m_axi_wready,

   input  logic [1:0]      m_axi_bresp,
   input  logic            m_axi_bvalid,
   output logic            m_axi_bready,

   output logic [AW-1:0]   m_axi_araddr,
   output logic [2:0]      m_axi_arprot,
   output logic            m_axi_arvalid,
   input  logic            m_axi_arready,

   input  logic [DW-1:0]   m_axi_rdata,
   input  logic [1:0]      m_axi_rresp,
   input  logic            m_axi_rvalid,
   output logic            m_axi_rready
);

   localparam int SW = DW / 8;

   state_t          state, state_nxt;
   logic            awvalid_q, awvalid_nxt;
   logic            wvalid_q, wvalid_nxt;
   logic            bready_q, bready_nxt;
   logic            arvalid_q, arvalid_nxt;
   logic            rready_q, rready_nxt;
   logic            pready_q, pready_nxt;
   logic            capture;
   logic            b_take;
   logic            r_take;

   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [SW-1:0]   strb_q;
   logic [2:0]      prot_q;
   logic [DW-1:0]   prdata_q;
   logic            pslverr_q;

   // All handshake outputs are next-state decoded here and registered below,
   // so no output has a combinational path from an input.
   always_comb begin
      state_nxt   = state;
      awvalid_nxt = 1'b0;
      wvalid_nxt  = 1'b0;
      bready_nxt  = 1'b0;
      arvalid_nxt = 1'b0;
      rready_nxt  = 1'b0;
      pready_nxt  = 1'b0;
      capture     = 1'b0;
      b_take      = 1'b0;
      r_take      = 1'b0;
      case (state)
         IDLE: begin
            if (s_apb_psel && !s_apb_penable) begin
               capture = 1'b1;
               if (s_apb_pwrite) begin
                  state_nxt   = WR_REQ;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
               end else begin
                  state_nxt   = RD_REQ;
                  arvalid_nxt = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // AW and W retire independently; a retired channel never re-asserts.
            awvalid_nxt = awvalid_q && !m_axi_awready;
            wvalid_nxt  = wvalid_q && !m_axi_wready;
            if (!awvalid_nxt && !wvalid_nxt) begin
               state_nxt  = WR_RSP;
               bready_nxt = 1'b1;
            end
         end
         WR_RSP: begin
            if (m_axi_bvalid) begin
               b_take     = 1'b1;
               state_nxt  = DONE;
               pready_nxt = 1'b1;
            end else begin
               bready_nxt = 1'b1;
            end
         end
         RD_REQ: begin
            if (m_axi_arready) begin
               state_nxt  = RD_RSP;
               rready_nxt = 1'b1;
            end else begin
               arvalid_nxt = 1'b1;
            end
         end
         RD_RSP: begin
            if (m_axi_rvalid) begin
               r_take     = 1'b1;
               state_nxt  = DONE;
               pready_nxt = 1'b1;
            end else begin
               rready_nxt = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or posedge sys_areset) begin
      if (sys_areset) begin
         state     <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         pready_q  <= 1'b0;
      end else begin
         state     <= state_nxt;
         awvalid_q <= awvalid_nxt;
         wvalid_q  <= wvalid_nxt;
         bready_q  <= bready_nxt;
         arvalid_q <= arvalid_nxt;
         rready_q  <= rready_nxt;
         pready_q  <= pready_nxt;
      end
   end

   // Setup-phase capture and AXI response capture.
   always_ff @(posedge axi_clk or posedge sys_areset) begin
      if (sys_areset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         prot_q    <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         if (capture) begin
            addr_q  <= s_apb_paddr;
            wdata_q <= s_apb_pwdata;
            strb_q  <= s_apb_pstrb;
            prot_q  <= s_apb_pprot;
         end
         if (b_take) begin
            pslverr_q <= resp_is_err(m_axi_bresp);
         end
         if (r_take) begin
            prdata_q  <= m_axi_rdata;
            pslverr_q <= resp_is_err(m_axi_rresp);
         end
      end
   end

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = prot_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = strb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = prot_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

   assign s_apb_pready  = pready_q;
   assign s_apb_prdata  = prdata_q;
   assign s_apb_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_to_axilite.sv
// Scoreboard bench for apb_to_axilite: APB master stimulus, a behavioural
// AXI-Lite slave with programmable stalls, and queue-based expectations.
module tb_apb_to_axilite;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            axi_clk = 1'b0;
   logic            sys_areset = 1'b1;
   logic [AW-1:0]   s_apb_paddr = '0;
   logic            s_apb_psel = 1'b0;
   logic            s_apb_penable = 1'b0;
   logic            s_apb_pwrite = 1'b0;
   logic [DW-1:0]   s_apb_pwdata = '0;
   logic [DW/8-1:0] s_apb_pstrb = '0;
   logic [2:0]      s_apb_pprot = '0;
   logic            s_apb_pready;
   logic [DW-1:0]   s_apb_prdata;
   logic            s_apb_pslverr;
   logic [AW-1:0]   m_axi_awaddr;
   logic [2:0]      m_axi_awprot;
   logic            m_axi_awvalid;
   logic            m_axi_awready = 1'b0;
   logic [DW-1:0]   m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic            m_axi_wvalid;
   logic            m_axi_wready = 1'b0;
   logic [1:0]      m_axi_bresp = '0;
   logic            m_axi_bvalid = 1'b0;
   logic            m_axi_bready;
   logic [AW-1:0]   m_axi_araddr;
   logic [2:0]      m_axi_arprot;
   logic            m_axi_arvalid;
   logic            m_axi_arready = 1'b0;
   logic [DW-1:0]   m_axi_rdata = '0;
   logic [1:0]      m_axi_rresp = '0;
   logic            m_axi_rvalid = 1'b0;
   logic            m_axi_rready;

   apb_to_axilite #(.AW(AW), .DW(DW)) dut (
      .axi_clk(axi_clk), .sys_areset(sys_areset),
      .s_apb_paddr(s_apb_paddr), .s_apb_psel(s_apb_psel), .s_apb_penable(s_apb_penable),
      .s_apb_pwrite(s_apb_pwrite), .s_apb_pwdata(s_apb_pwdata), .s_apb_pstrb(s_apb_pstrb),
      .s_apb_pprot(s_apb_pprot), .s_apb_pready(s_apb_pready), .s_apb_prdata(s_apb_prdata),
      .s_apb_pslverr(s_apb_pslverr),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 axi_clk = ~axi_clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  prot;
   } axi_op_t;

   typedef struct {
      bit          wr;
      logic [31:0] rdata;
      bit          err;
   } apb_rsp_t;

   axi_op_t  exp_axi[$];
   apb_rsp_t exp_apb[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Slave behaviour knobs for the transfer currently in flight.
   int          k_aw, k_w, k_b, k_ar, k_r;
   logic [1:0]  k_resp;
   logic [31:0] k_rdata;

   // Slave-side bookkeeping.
   bit aw_seen, w_seen, ar_seen, aw_got, w_got, b_pend, r_pend, b_hs, r_hs;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   int aw_hs_n = 0, w_hs_n = 0, awv_cycles = 0, wv_cycles = 0;

   always @(posedge axi_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic bit err_of(input logic [1:0] resp);
      return resp >= 2'd2;
   endfunction

   task automatic slave_clear();
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; aw_got = 0; w_got = 0;
      b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0;
   endtask

   task automatic on_aw();
      aw_hs_n++;
      if (exp_axi.size() == 0 || !exp_axi[0].wr) begin
         chk("aw_unexpected", 1, 0);
      end else begin
         chk("awaddr", m_axi_awaddr, exp_axi[0].addr);
         chk("awprot", m_axi_awprot, exp_axi[0].prot);
      end
      aw_got = 1;
   endtask

   task automatic on_w();
      w_hs_n++;
      if (exp_axi.size() == 0 || !exp_axi[0].wr) begin
         chk("w_unexpected", 1, 0);
      end else begin
         chk("wdata", m_axi_wdata, exp_axi[0].data);
         chk("wstrb", m_axi_wstrb, exp_axi[0].strb);
      end
      w_got = 1;
   endtask

   task automatic on_ar();
      if (exp_axi.size() == 0 || exp_axi[0].wr) begin
         chk("ar_unexpected", 1, 0);
      end else begin
         chk("araddr", m_axi_araddr, exp_axi[0].addr);
         chk("arprot", m_axi_arprot, exp_axi[0].prot);
         void'(exp_axi.pop_front());
      end
   endtask

   // AXI-Lite slave: acts at negedge; a ready/valid driven here handshakes at
   // the next posedge if the DUT side is already asserted.
   initial begin
      slave_clear();
      forever begin
         @(negedge axi_clk);
         if (sys_areset) begin
            slave_clear();
            continue;
         end
         if (m_axi_awvalid) awv_cycles++;
         if (m_axi_wvalid) wv_cycles++;

         if (m_axi_bvalid && b_hs) begin m_axi_bvalid = 0; b_pend = 0; end
         b_hs = 0;
         if (b_pend && !m_axi_bvalid) begin
            if (b_cnt == 0) begin m_axi_bvalid = 1; m_axi_bresp = k_resp; end
            else b_cnt--;
         end
         if (m_axi_bvalid) b_hs = m_axi_bready;

         if (m_axi_rvalid && r_hs) begin m_axi_rvalid = 0; r_pend = 0; end
         r_hs = 0;
         if (r_pend && !m_axi_rvalid) begin
            if (r_cnt == 0) begin
               m_axi_rvalid = 1; m_axi_rresp = k_resp; m_axi_rdata = k_rdata;
            end else r_cnt--;
         end
         if (m_axi_rvalid) r_hs = m_axi_rready;

         m_axi_awready = 0;
         if (m_axi_awvalid) begin
            if (!aw_seen) begin aw_seen = 1; aw_cnt = k_aw; end
            if (aw_cnt == 0) begin m_axi_awready = 1; aw_seen = 0; on_aw(); end
            else aw_cnt--;
         end
         m_axi_wready = 0;
         if (m_axi_wvalid) begin
            if (!w_seen) begin w_seen = 1; w_cnt = k_w; end
            if (w_cnt == 0) begin m_axi_wready = 1; w_seen = 0; on_w(); end
            else w_cnt--;
         end
         if (aw_got && w_got) begin
            aw_got = 0; w_got = 0; b_pend = 1; b_cnt = k_b;
            if (exp_axi.size() != 0) void'(exp_axi.pop_front());
         end
         m_axi_arready = 0;
         if (m_axi_arvalid) begin
            if (!ar_seen) begin ar_seen = 1; ar_cnt = k_ar; end
            if (ar_cnt == 0) begin
               m_axi_arready = 1; ar_seen = 0; on_ar(); r_pend = 1; r_cnt = k_r;
            end else ar_cnt--;
         end
      end
   end

   // APB response monitor.
   initial begin
      apb_rsp_t e;
      forever begin
         @(negedge axi_clk);
         if (!sys_areset && s_apb_pready) begin
            if (exp_apb.size() == 0) begin
               chk("pready_unexpected", 1, 0);
            end else begin
               e = exp_apb.pop_front();
               chk("pslverr", s_apb_pslverr, e.err);
               if (!e.wr) chk("prdata", s_apb_prdata, e.rdata);
            end
         end
      end
   end

   // Issue one APB transfer and wait (bounded) for pready; returns the number
   // of cycles from the setup phase to the pready cycle.
   task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p,
                           input logic [1:0] resp, input logic [31:0] rd,
                           input int daw, input int dw, input int db,
                           input int dar, input int dr, output int lat);
      axi_op_t  op;
      apb_rsp_t r;
      int t0;
      bit got;
      op.wr = wr; op.addr = a; op.data = d; op.strb = s; op.prot = p;
      r.wr = wr; r.rdata = rd; r.err = err_of(resp);
      exp_axi.push_back(op);
      exp_apb.push_back(r);
      k_aw = daw; k_w = dw; k_b = db; k_ar = dar; k_r = dr; k_resp = resp; k_rdata = rd;
      @(negedge axi_clk);
      s_apb_psel = 1; s_apb_penable = 0; s_apb_pwrite = wr; s_apb_paddr = a;
      s_apb_pwdata = d; s_apb_pstrb = s; s_apb_pprot = p;
      t0 = cyc;
      @(negedge axi_clk);
      s_apb_penable = 1;
      got = 0;
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         if (s_apb_pready) begin got = 1; lat = cyc - t0; break; end
         @(negedge axi_clk);
      end
      if (!got) chk("pready_timeout", 0, 1);
      // Leave the bus idle unless the caller follows straight on.
      s_apb_psel = 0;
      s_apb_penable = 0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_awvalid"}, m_axi_awvalid, 0);
      chk({tag, "_wvalid"}, m_axi_wvalid, 0);
      chk({tag, "_bready"}, m_axi_bready, 0);
      chk({tag, "_arvalid"}, m_axi_arvalid, 0);
      chk({tag, "_rready"}, m_axi_rready, 0);
      chk({tag, "_pready"}, s_apb_pready, 0);
      chk({tag, "_pslverr"}, s_apb_pslverr, 0);
      chk({tag, "_prdata"}, s_apb_prdata, 0);
      chk({tag, "_awaddr"}, m_axi_awaddr, 0);
   endtask

   initial begin
      int lat, a0, w0;
      bit got;
      axi_op_t  op;
      apb_rsp_t r;

      repeat (3) @(negedge axi_clk);
      chk_outputs_zero("reset");
      sys_areset = 0;
      repeat (2) @(negedge axi_clk);

      // Minimum-latency write.
      awv_cycles = 0; wv_cycles = 0;
      apb_xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 2'b00, 32'h0, 0, 0, 0, 0, 0, lat);
      chk("wr_min_latency", lat, 3);
      chk("wr_min_awv_cycles", awv_cycles, 1);
      chk("wr_min_wv_cycles", wv_cycles, 1);

      // Read with 5 stall cycles on rvalid.
      apb_xfer(0, 32'h20, 32'h0, 4'h0, 3'd2, 2'b00, 32'h12345678, 0, 0, 0, 0, 5, lat);
      chk("rd_stall_latency", lat, 8);

      // W lags AW by 3 cycles.
      awv_cycles = 0; wv_cycles = 0; a0 = aw_hs_n; w0 = w_hs_n;
      apb_xfer(1, 32'h44, 32'hA5A5_0F0F, 4'h6, 3'd5, 2'b01, 32'h0, 0, 3, 0, 0, 0, lat);
      chk("wlag_awv_cycles", awv_cycles, 1);
      chk("wlag_wv_cycles", wv_cycles, 4);
      chk("wlag_aw_hs", aw_hs_n - a0, 1);
      chk("wlag_w_hs", w_hs_n - w0, 1);

      // Error responses.
      apb_xfer(0, 32'h80, 32'h0, 4'h0, 3'd0, 2'b10, 32'hCAFE_F00D, 0, 0, 0, 1, 0, lat);
      apb_xfer(1, 32'h84, 32'h1111_2222, 4'h3, 3'd1, 2'b11, 32'h0, 1, 0, 2, 0, 0, lat);

      // Reset while waiting in WR_RSP.
      op.wr = 1; op.addr = 32'h90; op.data = 32'h5555_AAAA; op.strb = 4'hF; op.prot = 3'd0;
      r.wr = 1; r.rdata = 0; r.err = 0;
      exp_axi.push_back(op);
      exp_apb.push_back(r);
      k_aw = 0; k_w = 0; k_b = 50; k_ar = 0; k_r = 0; k_resp = 2'b00;
      @(negedge axi_clk);
      s_apb_psel = 1; s_apb_penable = 0; s_apb_pwrite = 1; s_apb_paddr = 32'h90;
      s_apb_pwdata = 32'h5555_AAAA; s_apb_pstrb = 4'hF; s_apb_pprot = 3'd0;
      @(negedge axi_clk);
      s_apb_penable = 1;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         if (m_axi_bready) begin got = 1; break; end
         @(negedge axi_clk);
      end
      chk("rst_reach_wr_rsp", got, 1);
      @(posedge axi_clk);
      #2 sys_areset = 1;
      #1 chk_outputs_zero("midrst");
      exp_axi.delete();
      exp_apb.delete();
      s_apb_psel = 0; s_apb_penable = 0;
      repeat (2) @(negedge axi_clk);
      sys_areset = 0;
      apb_xfer(0, 32'h24, 32'h0, 4'h0, 3'd3, 2'b01, 32'h0BAD_BEEF, 0, 0, 0, 1, 1, lat);
      chk("post_rst_rd_latency", lat, 5);

      // Alternating random traffic.
      for (int i = 0; i < 50; i++) begin
         logic [31:0] ra, rdd, rdat;
         ra = $urandom & 32'hFFFF_FFFC;
         rdd = $urandom;
         rdat = $urandom;
         apb_xfer((i % 2) == 0, ra, rdd, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), rdat,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), lat);
      end

      repeat (3) @(negedge axi_clk);
      chk("exp_axi_drained", exp_axi.size(), 0);
      chk("exp_apb_drained", exp_apb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_to_axilite.md
# apb_to_axilite

Single-clock bridge that accepts transfers on an APB slave port and replays each one as a single AXI4-Lite transaction on an AXI-Lite master port. It is the reverse-direction companion of the AXI-Lite→APB converter. It lets APB-side initiators such as debug or config masters reach AXI-Lite register space. Exactly one transfer is in flight at a time, and the APB access phase is stretched with PREADY until the AXI response returns.

## Interface
Parameters:
- AW, 32, address width on both ports
- DW, 32, data width on both ports; strobe width is DW/8

Ports:
- axi_clk  in  1  single clock for both ports
- sys_areset  in  1  asynchronous, active-high reset
- s_apb_paddr  in  AW  APB address
- s_apb_psel  in  1  APB select
- s_apb_penable  in  1  APB enable (access phase)
- s_apb_pwrite  in  1  1 = write
- s_apb_pwdata  in  DW  write data
- s_apb_pstrb  in  DW/8  write strobes
- s_apb_pprot  in  3  protection
- s_apb_pready  out  1  transfer complete
- s_apb_prdata  out  DW  read data
- s_apb_pslverr  out  1  error response
- m_axi_awaddr/awprot/awvalid out, awready in: AXI write address channel
- m_axi_wdata/wstrb/wvalid out, wready in: AXI write data channel
- m_axi_bresp/bvalid in, bready out: AXI write response channel
- m_axi_araddr/arprot/arvalid out, arready in: AXI read address channel
- m_axi_rdata/rresp/rvalid in, rready out: AXI read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE.
- **IDLE:** when psel=1 and penable=0 (setup phase), register paddr, pwrite, pwdata, pstrb and pprot.
  - pwrite=1 → WR_REQ.
  - pwrite=0 → RD_REQ.
- **WR_REQ:**
  - awvalid and wvalid both assert on state entry.
  - Each one drops independently on its own handshake (valid&ready).
  - When both handshakes are done (including in the same cycle) → WR_RSP.
  - awaddr, wdata and wstrb come from the registered copies; awprot = pprot.
- **WR_RSP:**
  - bready=1.
  - On bvalid: registered pslverr ← bresp[1]; go to DONE.
- **RD_REQ:**
  - arvalid=1; araddr comes from the registered copy; arprot = pprot.
  - On arready → RD_RSP.
- **RD_RSP:**
  - rready=1.
  - On rvalid: prdata register ← rdata; pslverr ← rresp[1]; go to DONE.
- **DONE:** pready=1 for exactly one cycle, then → IDLE.
- pstrb is ignored for reads. OKAY and EXOKAY both map to pslverr=0; SLVERR and DECERR both map to 1.
- All AXI valid/ready outputs and pready are registered. They do not depend combinationally on inputs.
- Reset values: all valid/ready outputs, pready and pslverr are 0; prdata and all address/data registers are 0; state is IDLE.
- prdata holds its last value after DONE. pslverr is only meaningful while pready=1.

## Timing
- Setup phase at cycle T0 (capture). AXI valids assert at T1.
- Minimum write latency, with awready, wready and bvalid all already high: AW/W handshake at T1, bready at T2 with bvalid, pready at T3. That is 2 wait states on APB.
- Read minimum is the same shape: AR handshake at T1, R handshake at T2, pready at T3.
- AXI stalls extend the wait states without bound. There is no timeout.
- If AW completes before W, or W before AW, awvalid or wvalid stays low after its handshake. It never re-asserts.
- If psel drops before DONE (an APB protocol violation), the AXI transaction still completes and the pready pulse is still issued. The bridge then returns to IDLE.
- A new setup phase is accepted only in IDLE. The DONE→IDLE cycle coincides with the APB initiator's next setup phase.
- Asserting sys_areset mid-transaction clears all outputs immediately. The AXI slave must be reset in the same domain.

## Structure
- Shared package axilite_apb_pkg holds:
  - the state enum typedef,
  - the AXI response constants (OKAY, EXOKAY, SLVERR, DECERR),
  - the default AW/DW values.
- The bridge is a single module with no sub-modules. The FSM and the capture registers live in one file.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010, strobe 0xF, with AXI slave always ready and bvalid immediate → AW/W at T1, pready at T3, pslverr=0.
- Read from 0x0000_0020, slave returns rdata 0x1234_5678 with OKAY after 5 stall cycles on rvalid → prdata=0x12345678 during the pready cycle, which arrives 5 cycles later than minimum.
- Write with wready delayed 3 cycles past awready → awvalid deasserts after 1 cycle, wvalid holds 4 cycles; exactly one AW and one W handshake occur.
- Read with rresp=SLVERR, then write with bresp=DECERR → pslverr=1 in both pready cycles.
- Reset asserted while in WR_RSP → all outputs 0 asynchronously; after release, a fresh read completes normally.
- Back-to-back alternating write/read, 50 random transfers → AXI order matches APB order, and each write's wdata/wstrb are unchanged.
